// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
//   sw_state_t  : run-control FSM states (IDLE, RUN, PAUSE)
//   bcd_digit_t : one BCD digit (0..9)
//   BCD_MAX     : largest legal BCD digit value
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// One decade of the BCD time counter. Chained four deep in the stopwatch core.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset (digit -> 0)
//   clear : synchronous clear (digit -> 0), same effect as reset
//   inc   : advance this digit by one this cycle
//   digit : current BCD value, 0..9
//   carry : inc & (digit == 9); drives inc of the next-higher digit
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output bcd_digit_t digit,
  output logic       carry
);

  assign carry = inc & (digit == BCD_MAX);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      digit <= '0;
    end else if (inc) begin
      digit <= (digit == BCD_MAX) ? bcd_digit_t'(0) : bcd_digit_t'(digit + 4'd1);
    end
  end

endmodule

// File: rtl/stopwatch_time_core.sv
// Stopwatch timekeeping engine: counts hundredths of a second 00.00..99.99 as
// four BCD digits for the seven-segment display controller.
// Ports:
//   clk                : system clock (100 MHz)
//   reset              : synchronous, active-high reset
//   start              : debounced start/stop level; each rising edge toggles run/pause
//   clear              : debounced clear level; returns to IDLE with zero time
//   lap                : (only with STOPWATCH_LAP_EN) debounced lap level; rising
//                        edge freezes / releases the displayed value
//   HEX_display_digits : {tens s, s, tenths, hundredths} in BCD
//   running            : high while the FSM is in RUN
//   overflow           : sticky, set when the count wraps 99.99 -> 00.00
// Optional feature macro: STOPWATCH_LAP_EN (lap freeze display).
module stopwatch_time_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
`endif
  output logic [15:0] HEX_display_digits,
  output logic        running,
  output logic        overflow
);

  localparam int DIV_W = $clog2(TICK_DIV);

  sw_state_t        state;
  logic [DIV_W-1:0] prescaler;
  logic             start_q;
  logic             start_edge;
  logic             tick;
  logic [3:0]       inc;
  logic [3:0]       carry;
  bcd_digit_t       digit [4];
  logic [15:0]      live;

  assign start_edge = start & ~start_q;
  assign tick       = (state == RUN) && (prescaler == DIV_W'(TICK_DIV - 1));

  // Ripple enable: a digit advances only when every lower digit rolls over.
  assign inc = {carry[2:0], tick};

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (inc[i]),
      .digit (digit[i]),
      .carry (carry[i])
    );
  end

  assign live = {digit[3], digit[2], digit[1], digit[0]};

  // Run-control FSM, prescaler and flags. A start edge coinciding with a tick
  // still lets the tick land (digits update in their own counters) while the
  // state moves on.
  always_ff @(posedge clk) begin
    start_q <= start;
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      running   <= 1'b0;
      overflow  <= 1'b0;
      start_q   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      prescaler <= '0;
      running   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (state == RUN) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
      end
      if (carry[3]) begin
        overflow <= 1'b1;
      end
      if (start_edge) begin
        case (state)
          IDLE:    begin state <= RUN;   running <= 1'b1; end
          RUN:     begin state <= PAUSE; running <= 1'b0; end
          PAUSE:   begin state <= RUN;   running <= 1'b1; end
          default: begin state <= IDLE;  running <= 1'b0; end
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_q;
  logic        frozen;
  logic [15:0] snapshot;

  // Lap edges only matter once timing has begun; IDLE ignores them.
  always_ff @(posedge clk) begin
    lap_q <= lap;
    if (reset) begin
      lap_q  <= 1'b0;
      frozen <= 1'b0;
    end else if (clear) begin
      frozen <= 1'b0;
    end else if (lap && !lap_q && state != IDLE) begin
      frozen <= ~frozen;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear && lap && !lap_q && state != IDLE && !frozen) begin
      snapshot <= live;
    end
  end

  assign HEX_display_digits = frozen ? snapshot : live;
`else
  assign HEX_display_digits = live;
`endif

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Directed bench for stopwatch_time_core with TICK_DIV = 4.
module tb_stopwatch_time_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        clear;
`ifdef STOPWATCH_LAP_EN
  logic        lap;
`endif
  logic [15:0] HEX_display_digits;
  logic        running;
  logic        overflow;

  int total_cnt = 0;
  int pass_cnt  = 0;

  stopwatch_time_core #(.TICK_DIV(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .clear              (clear),
`ifdef STOPWATCH_LAP_EN
    .lap                (lap),
`endif
    .HEX_display_digits (HEX_display_digits),
    .running            (running),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [15:0] d, input logic r, input logic o);
    chk({tag, "_digits"},   HEX_display_digits, d);
    chk({tag, "_running"},  {15'd0, running},   {15'd0, r});
    chk({tag, "_overflow"}, {15'd0, overflow},  {15'd0, o});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    cyc(2);
    chk_all("reset", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(2);
    chk_all("idle", 16'h0000, 1'b0, 1'b0);

    // Start held high: enter RUN, first tick after 4 cycles.
    start = 1'b1;
    cyc(1);
    chk_all("enter_run", 16'h0000, 1'b1, 1'b0);
    cyc(3);
    chk("pre_tick", HEX_display_digits, 16'h0000);
    cyc(1);
    chk("first_tick", HEX_display_digits, 16'h0001);
    cyc(36);
    chk_all("ten_ticks", 16'h0010, 1'b1, 1'b0);

    // Run to 9.99, then pause mid-prescaler (prescaler ends at 3).
    cyc(3956);
    chk("at_0999", HEX_display_digits, 16'h0999);
    cyc(1);
    start = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    chk_all("pause", 16'h0999, 1'b0, 1'b0);
    cyc(100);
    chk_all("paused_hold", 16'h0999, 1'b0, 1'b0);
    start = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    chk_all("resume", 16'h0999, 1'b1, 1'b0);
    cyc(1);
    chk("resume_tick", HEX_display_digits, 16'h1000);

    // Run to 99.99 and wrap.
    cyc(35996);
    chk_all("at_9999", 16'h9999, 1'b1, 1'b0);
    cyc(4);
    chk_all("wrap", 16'h0000, 1'b1, 1'b1);
    cyc(8);
    chk_all("post_wrap", 16'h0002, 1'b1, 1'b1);

    // Clear returns to IDLE and drops overflow; holding clear keeps it there.
    clear = 1'b1; cyc(1);
    chk_all("clear", 16'h0000, 1'b0, 1'b0);
    cyc(3);
    clear = 1'b0; cyc(4);
    chk_all("after_clear", 16'h0000, 1'b0, 1'b0);

    // Start edge simultaneous with clear while running: clear wins.
    start = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    chk("restart_running", {15'd0, running}, 16'h0001);
    cyc(5);
    chk("restart_count", HEX_display_digits, 16'h0001);
    start = 1'b0; cyc(1);
    start = 1'b1; clear = 1'b1; cyc(1);
    chk_all("edge_and_clear", 16'h0000, 1'b0, 1'b0);
    clear = 1'b0; cyc(8);
    chk_all("edge_and_clear_hold", 16'h0000, 1'b0, 1'b0);

    // Start held for 50 cycles: a single transition into RUN.
    start = 1'b0; cyc(1);
    start = 1'b1; cyc(50);
    chk_all("held_start", 16'h0012, 1'b1, 1'b0);

    // Reset mid-count.
    reset = 1'b1; start = 1'b0; cyc(1);
    chk_all("mid_reset", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0; cyc(3);
    chk_all("post_reset", 16'h0000, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
    // Lap edge in IDLE is ignored.
    lap = 1'b1; cyc(1);
    lap = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    chk("lap_idle_run", {15'd0, running}, 16'h0001);
    cyc(48);
    chk("lap_pre", HEX_display_digits, 16'h0012);
    lap = 1'b1; cyc(1);
    chk("lap_frozen", HEX_display_digits, 16'h0012);
    cyc(31);
    chk("lap_frozen_hold", HEX_display_digits, 16'h0012);
    lap = 1'b0; cyc(1);
    lap = 1'b1; cyc(1);
    chk("lap_release", HEX_display_digits, 16'h0020);
    lap = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
